// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate one-word-line data cache.
// Ports: clk/rst (sync, active-high); r_ena/w_ena/ext/width/addr/data_in request, ready when idle;
// valid/data_out completion; mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb/mem_ack/mem_rdata backing bus.
// Optional DCACHE_MMIO_BYPASS_EN makes addr[31:28]==4'hF uncached.
module dcache #(
  parameter int LINES = 64,
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_ena,
  input  logic              w_ena,
  input  logic              ext,
  input  logic [1:0]        width,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  output logic              valid,
  output logic [31:0]       data_out,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;
  state_t state;
  logic [31:0] line_data [LINES];
  logic [TW-1:0] line_tag [LINES];
  logic [LINES-1:0] line_v;
  logic [31:0] a_addr;
  logic [1:0] a_width;
  logic a_ext;
  logic [IW-1:0] idx, a_idx;
  logic [TW-1:0] tag, a_tag;
  logic mmio, a_mmio, hit, store_hit, fill;
  logic [3:0] wstrb_n;
  logic [31:0] wdata_n, hit_word, merged;
  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] wd, input logic ze);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    return wd[1] ? w : wd[0] ? {ze ? 16'h0 : {16{h[15]}}, h} : {ze ? 24'h0 : {24{b[7]}}, b};
  endfunction
  assign idx = addr[IW+1:2];
  assign tag = addr[31:IW+2];
  assign a_idx = a_addr[IW+1:2];
  assign a_tag = a_addr[31:IW+2];
`ifdef DCACHE_MMIO_BYPASS_EN
  assign mmio = addr[31:28] == 4'hF;
  assign a_mmio = a_addr[31:28] == 4'hF;
`else
  assign mmio = 1'b0;
  assign a_mmio = 1'b0;
`endif
  assign hit_word = line_data[idx];
  assign hit = line_v[idx] && line_tag[idx] == tag && !mmio;
  assign ready = state == IDLE;
  assign wstrb_n = width[1] ? 4'b1111 : width[0] ? 4'b0011 << {addr[1], 1'b0} : 4'b0001 << addr[1:0];
  assign wdata_n = width[1] ? data_in : width[0] ? {2{data_in[15:0]}} : {4{data_in[7:0]}};
  assign store_hit = ready && w_ena && hit;
  assign fill = state == REFILL && mem_ack && !a_mmio;
  always_comb begin
    merged = hit_word;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = wstrb_n[i] ? wdata_n[8*i +: 8] : hit_word[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) line_data[idx] <= merged;
      if (fill) begin
        line_data[a_idx] <= mem_rdata;
        line_tag[a_idx] <= a_tag;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      line_v <= '0;
      valid <= 1'b0;
      data_out <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      a_addr <= '0;
      a_width <= '0;
      a_ext <= 1'b0;
    end else begin
      case (state)
        IDLE: if (r_ena || w_ena) begin
          a_addr <= addr;
          a_width <= width;
          a_ext <= ext;
          mem_addr <= MEM_AW'({addr[31:2], 2'b00});
          if (w_ena) begin
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_wdata <= wdata_n;
            mem_wstrb <= wstrb_n;
            state <= WRITE;
          end else if (hit) begin
            data_out <= ext_load(hit_word, addr[1:0], width, ext);
            valid <= 1'b1;
            state <= RESP;
          end else begin
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            state <= REFILL;
          end
        end
        REFILL: if (mem_ack) begin
          mem_req <= 1'b0;
          data_out <= ext_load(mem_rdata, a_addr[1:0], a_width, a_ext);
          valid <= 1'b1;
          state <= RESP;
          if (!a_mmio) line_v[a_idx] <= 1'b1;
        end
        WRITE: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          mem_wstrb <= '0;
          valid <= 1'b1;
          state <= RESP;
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of one-word direct-mapped lines (power of two, >=2).
REQ-002 SHALL have parameter MEM_AW, default 32, backing-bus address width.
REQ-003 SHALL provide ports clk in 1 clock; rst in 1 reset.
REQ-004 SHALL provide: r_ena in 1 load request; w_ena in 1 store request; ext in 1 (1=zero-extend, 0=sign-extend); width in 2 (00 byte, 01 half, 10/11 word); addr in 32 byte address; data_in in 32 store data (low lanes).
REQ-005 SHALL provide: valid out 1 completion pulse; data_out out 32 extended load data; ready out 1 able to accept request.
REQ-006 SHALL provide: mem_req out 1; mem_we out 1; mem_addr out MEM_AW word-aligned; mem_wdata out 32; mem_wstrb out 4; mem_ack in 1; mem_rdata in 32.
REQ-007 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-008 SHALL index with addr[2+log2(LINES)-1:2] and tag with the remaining upper bits; addr[1:0] selects lanes; half ignores addr[0]; word ignores addr[1:0].
REQ-009 SHALL implement states IDLE, REFILL, WRITE, RESP; ready=1 only in IDLE.
REQ-010 SHALL in IDLE accept a request in cycle N when r_ena|w_ena, registering addr, width, ext, data_in; w_ena has priority when both are high (load dropped, no response for it).
REQ-011 SHALL ignore r_ena/w_ena when not in IDLE.
REQ-012 Read hit SHALL go IDLE->RESP, with valid=1 and data_out updated in cycle N+1 and no bus activity.
REQ-013 Read miss SHALL go IDLE->REFILL; mem_req=1, mem_we=0, mem_addr={addr[31:2],00} from N+1 through the mem_ack cycle inclusive.
REQ-014 On mem_ack in REFILL SHALL write mem_rdata, tag, valid bit into the line and go to RESP, with the load result taken from mem_rdata.
REQ-015 Store SHALL go IDLE->WRITE (write-through, no write-allocate); mem_req=1, mem_we=1 until mem_ack inclusive.
REQ-016 Store mem_wdata SHALL replicate lanes (byte x4, half x2, word as-is); mem_wstrb SHALL be 0001<<addr[1:0], 0011<<{addr[1],0}, or 1111.
REQ-017 Store hit SHALL merge strobed bytes into the line on acceptance; store miss SHALL leave the array unchanged.
REQ-018 RESP SHALL last one cycle (valid=1), then return to IDLE; valid SHALL be 1 in no other state.
REQ-019 data_out SHALL hold the last load result until the next load completes; stores do not change it.
REQ-020 Load extension: byte/half selected by lanes; ext=0 sign-extends from bit 7/15, ext=1 zero-extends.
REQ-021 mem_ack outside REFILL/WRITE SHALL be ignored; mem_req SHALL deassert the cycle after mem_ack.

Reset
REQ-022 rst SHALL force IDLE and clear all line valid bits in that cycle; valid=0, data_out=0, mem_req=0, mem_we=0, mem_wstrb=0, ready=1 after reset.
REQ-023 rst mid-REFILL/WRITE SHALL abandon the transaction without line update or valid pulse; a later stray mem_ack SHALL be ignored.

Configuration
REQ-024 With DCACHE_MMIO_BYPASS_EN defined, addresses with addr[31:28]==4'hF SHALL be uncached: loads always take REFILL without allocating a line; stores never update a line.
REQ-025 Without DCACHE_MMIO_BYPASS_EN, all addresses SHALL be cacheable per REQ-012..REQ-017.

Verification
REQ-026 Cold load word 0x00001000; bus answers 0xDEADBEEF after 3 cycles -> mem_req 3 cycles at 0x00001000, valid the cycle after ack, data_out=0xDEADBEEF; repeat load -> valid at N+1, no mem_req.
REQ-027 After REQ-026 fill, store byte 0x5A to 0x00001002 -> mem_wstrb=0100, mem_wdata=0x5A5A5A5A; then load byte ext=0 at 0x00001002 -> hit, data_out=0x0000005A; load byte ext=0 at 0x00001003 -> 0xFFFFFFDE.
REQ-028 Load half ext=1 at 0x00001002 after REQ-027 -> data_out=0x0000DE5A; ext=0 -> 0xFFFFDE5A.
REQ-029 LINES=64: fill 0x00001000, then load 0x00001100 (same index, different tag) -> miss, refill; reload 0x00001000 -> miss again.
REQ-030 rst asserted during REFILL, then mem_ack -> no valid pulse; next load of same address misses; r_ena and w_ena together -> only store issued (mem_we=1), single valid.
REQ-031 With DCACHE_MMIO_BYPASS_EN, two loads of 0xF0000000 returning 1 then 2 -> both issue mem_req, data_out 1 then 2.
